// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the master modport; the stream source / memory model takes the slave modport.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 14
);
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_wr_en;
   logic [31:0]       imem_data;

   modport master (
      input  s_data, s_valid,
      output s_ready, imem_addr, imem_wr_en, imem_data
   );

   modport slave (
      output s_data, s_valid,
      input  s_ready, imem_addr, imem_wr_en, imem_data
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory
// and holds the core stalled until the load completes.
module imem_boot_loader #(
   parameter int                ADDR_W    = 14,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst,
   imem_boot_loader_if.master  bus,
   input  logic                start,
   output logic                core_hold,
   output logic                done,
   output logic                err,
   output logic [12:0]         words_loaded
);

   typedef enum logic [2:0] {HDR_LO, HDR_HI, LOAD, WRITE, DONE, ERR} state_t;

   state_t            state_q, state_d;
   logic [12:0]       n_q, n_d;
   logic [12:0]       wl_q, wl_d;
   logic [1:0]        k_q, k_d;
   logic [23:0]       asm_q, asm_d;
   logic              ready_q, ready_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;

   logic              xfer;
   logic [12:0]       n_hdr;

   // ready is a register, so a transfer depends only on state and s_valid
   assign xfer  = bus.s_valid & ready_q;
   assign n_hdr = {bus.s_data[4:0], n_q[7:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HDR_LO;
         n_q     <= '0;
         wl_q    <= '0;
         k_q     <= '0;
         asm_q   <= '0;
         ready_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wl_q    <= wl_d;
         k_q     <= k_d;
         asm_q   <= asm_d;
         ready_q <= ready_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wl_d    = wl_q;
      k_d     = k_q;
      asm_d   = asm_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;

      case (state_q)
         HDR_LO: begin
            if (xfer) begin
               n_d     = {5'd0, bus.s_data};
               state_d = HDR_HI;
            end
         end

         HDR_HI: begin
            if (xfer) begin
               n_d = n_hdr;
               k_d = '0;
               if (n_hdr == 13'd0)         state_d = DONE;
               else if (n_hdr > 13'd4096)  state_d = ERR;
               else                        state_d = LOAD;
            end
         end

         LOAD: begin
            if (xfer) begin
               if (k_q == 2'd3) begin
                  // last byte goes straight into the output word; no fourth assembly byte needed
                  state_d = WRITE;
                  wr_d    = 1'b1;
                  data_d  = {bus.s_data, asm_q};
                  addr_d  = BASE_ADDR + ADDR_W'({wl_q, 2'b00});
                  k_d     = '0;
               end else begin
                  case (k_q)
                     2'd0:    asm_d[7:0]   = bus.s_data;
                     2'd1:    asm_d[15:8]  = bus.s_data;
                     default: asm_d[23:16] = bus.s_data;
                  endcase
                  k_d = k_q + 2'd1;
               end
            end
         end

         WRITE: begin
            wl_d    = wl_q + 13'd1;
            state_d = (wl_q + 13'd1 == n_q) ? DONE : LOAD;
         end

         DONE, ERR: begin
            if (start) begin
               wl_d    = '0;
               k_d     = '0;
               n_d     = '0;
               state_d = HDR_LO;
            end
         end

         default: state_d = HDR_LO;
      endcase

      ready_d = (state_d == HDR_LO) || (state_d == HDR_HI) || (state_d == LOAD);
   end

   assign bus.s_ready    = ready_q;
   assign bus.imem_wr_en = wr_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_data  = data_q;

   assign core_hold    = (state_q != DONE);
   assign done         = (state_q == DONE);
   assign err          = (state_q == ERR);
   assign words_loaded = wl_q;

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 14, byte-address width of instruction memory port.
REQ-002 SHALL have parameter: BASE_ADDR, 14'h0000, byte address of first loaded word (multiple of 4).
REQ-003 SHALL have port: clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: s_data  input  8  incoming program byte stream.
REQ-006 SHALL have port: s_valid  input  1  s_data valid.
REQ-007 SHALL have port: s_ready  output  1  loader accepts byte; transfer = s_valid & s_ready at clk edge.
REQ-008 SHALL have port: start  input  1  one-cycle pulse; restarts a load from DONE or ERR.
REQ-009 SHALL have port: imem_addr  output  ADDR_W  byte address to instruction memory.
REQ-010 SHALL have port: imem_wr_en  output  1  instruction memory write strobe.
REQ-011 SHALL have port: imem_data  output  32  word to write.
REQ-012 SHALL have port: core_hold  output  1  high while the core must stay stalled.
REQ-013 SHALL have port: done  output  1  load completed successfully.
REQ-014 SHALL have port: err  output  1  header rejected.
REQ-015 SHALL have port: words_loaded  output  13  count of words written this load.

Function
REQ-016 SHALL implement states HDR_LO, HDR_HI, LOAD, WRITE, DONE, ERR.
REQ-017 SHALL assert s_ready only in HDR_LO, HDR_HI, LOAD; s_ready SHALL be registered, never combinational from s_valid.
REQ-018 HDR_LO: accepted byte -> N[7:0]; go HDR_HI.
REQ-019 HDR_HI: accepted byte -> N[12:8] (bits 7:5 of byte ignored); next state DONE if N=0, ERR if N>4096, else LOAD.
REQ-020 LOAD: accepted byte k (k=0..3) SHALL land in word bits [8k+7:8k] (little-endian); after k=3 go WRITE.
REQ-021 WRITE SHALL last exactly one cycle with imem_wr_en=1, imem_data=assembled word, imem_addr=(BASE_ADDR+4*words_loaded) mod 2^ADDR_W.
REQ-022 Cycle after WRITE: words_loaded increments by 1; state DONE if new count = N, else LOAD with k=0.
REQ-023 imem_wr_en, imem_addr, imem_data SHALL be registered outputs; imem_wr_en=0 in all states except WRITE.
REQ-024 Minimum throughput: 5 cycles per word (4 byte cycles + 1 WRITE); idle s_valid cycles SHALL only stall, never corrupt k or the assembly register.
REQ-025 core_hold=1 in all states except DONE; done=1 only in DONE; err=1 only in ERR.
REQ-026 DONE/ERR: start=1 SHALL clear words_loaded, k, N and enter HDR_LO next cycle; start ignored in other states.
REQ-027 imem_addr SHALL hold its last value outside WRITE; memory write latency is the consumer's concern.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state HDR_LO, s_ready=0 until first clk edge after rst release, imem_wr_en=0, imem_addr=BASE_ADDR, imem_data=0, words_loaded=0, k=0, N=0, core_hold=1, done=0, err=0.
REQ-029 Reset mid-load SHALL abort without completing a partial word; words already written are not erased.

Verification
REQ-030 Header 02 00, bytes 13 00 00 00 B7 02 01 00 -> writes 0x00000013 @0x0000, 0x000102B7 @0x0004; done=1, core_hold=0, words_loaded=2.
REQ-031 Header 00 00 -> DONE next cycle, no imem_wr_en pulse, words_loaded=0.
REQ-032 Header 01 10 (N=4097) -> ERR, err=1, core_hold=1, no write; start pulse -> HDR_LO, err=0.
REQ-033 N=1 with s_valid low on random cycles between bytes -> single write of correct word, imem_wr_en high exactly one cycle.
REQ-034 rst asserted after 2 payload bytes of word 1 -> imem_wr_en stays 0, outputs at reset values; new full load then writes from BASE_ADDR.
REQ-035 BASE_ADDR=14'h3FFC, N=2 -> writes at 0x3FFC then 0x0000 (wrap).
